box_overlay: RTL and testbench
==============================

// Module: box_overlay
// PURPOSE
//  Multi-box window overlay on the HDMI video path: draws up to N_BOX rectangular frames over a
//  pixel stream that carries x/y coordinates. Successor to the fixed single-box window drawer.
//  Boxes are runtime-programmable (coords, colour, enable), double-buffered and committed at frame
//  start so targets move without tearing. Sits between hdmi_display and the HDMI output pins.
// PARAMETERS
//  N_BOX        4   number of box slots (1..16)
//  X_WIDTH      11  pixel x coordinate width
//  Y_WIDTH      10  pixel y coordinate width
//  V_BOX_WIDTH  2   thickness in pixels of the left/right (vertical) edges
//  H_BOX_WIDTH  2   thickness in rows of the top/bottom (horizontal) edges
// PORTS
//  clk        in   1            pixel clock; all logic on rising edge
//  rst        in   1            synchronous reset, active-high
//  cfg_we     in   1            write one box slot into the shadow table
//  cfg_idx    in   $clog2(N_BOX) slot index; writes with cfg_idx >= N_BOX are ignored
//  cfg_en     in   1            slot enable
//  cfg_xs/xe  in   X_WIDTH      start/end column, inclusive
//  cfg_ys/ye  in   Y_WIDTH      start/end row, inclusive
//  cfg_color  in   24           {R,G,B} edge colour
//  i_hsync, i_vsync, i_de in 1  input timing
//  i_x / i_y  in   X_WIDTH/Y_WIDTH  coordinate of the current pixel
//  i_r/i_g/i_b in  8            input pixel
//  o_hsync, o_vsync, o_de out 1 timing, delayed to match the pixel pipeline
//  o_r/o_g/o_b out 8            output pixel
//  o_hit      out  1            current output pixel lies on some box edge
//  o_hit_idx  out  $clog2(N_BOX) winning slot (0 when o_hit=0)
// BEHAVIOUR
//  - Reset: all shadow and active slots are cleared (en=0, coords 0, colour 0); all outputs are 0;
//    vsync edge detector is cleared. A reset mid-frame drops every in-flight pixel.
//  - Shadow write: on cfg_we the slot is written at the clock edge; no handshake, one write/cycle.
//  - Commit: a rising edge of i_vsync (i_vsync=1, registered copy=0) copies the entire shadow table
//    to the active table. When cfg_we and a commit fall in the same cycle, the commit takes the
//    pre-write shadow; the new value commits on the next vsync rise.
//  - Hit test (active slot k): en & xs<=xe & ys<=ye & xs<=x<=xe & ys<=y<=ye, and
//    (x < xs+V_BOX_WIDTH | x > xe-V_BOX_WIDTH | y < ys+H_BOX_WIDTH | y > ye-H_BOX_WIDTH).
//    Sums/differences computed one bit wider than the coordinate; xs+W past the max coordinate
//    saturates, and xe-W below 0 clamps to 0. A box thinner than 2*W is fully filled.
//  - Slots with xs>xe or ys>ye never hit. Edges are inclusive, so xs=xe draws a 1-px column.
//  - Priority: among overlapping hits, the lowest index wins.
//  - Pipeline: fixed 2-cycle latency. Stage 1 registers the per-slot hit vector plus the delayed
//    pixel and timing. Stage 2 does the priority encode and colour mux and registers the outputs.
//    Timing signals are delayed by exactly 2 cycles. No stall and no backpressure.
//  - When i_de=0 the pixel passes through unchanged and o_hit is forced to 0.
//  - A commit takes effect for pixels sampled on the cycle after the commit edge.
// CONFIGURATION
//  BOX_OVERLAY_ALPHA_EN
//   - Defined: an edge pixel is ((color>>1) + (pixel>>1)) per 8-bit channel, a 50% blend with no
//     rounding and no overflow.
//   - Undefined: an edge pixel is replaced by color.
//   - Latency, o_hit and o_hit_idx are the same in both builds.
// STRUCTURE
//  - Package box_overlay_pkg holds:
//    - typedef box_t {en, xs, xe, ys, ye, color}, parameterised via X_WIDTH/Y_WIDTH localparams;
//    - BOX_CLEAR constant;
//    - function blend50().
//  - Sub-module box_hit: combinational single-slot edge test (box_t + x/y -> hit). It is
//    instantiated N_BOX times in a generate loop. Tables, commit logic and the pipeline stay in
//    box_overlay.
// TESTING
//  1. Reset: hold rst for 3 cycles with a random input stream.
//     -> All outputs are 0. After release, the stream passes through unchanged with 2-cycle delay.
//  2. Single box: slot0 = (xs10, xe20, ys5, ye15, FF0000), W=2, vsync rise, then scan a frame.
//     -> Pixel (10,8) is red with o_hit_idx=0. (12,8) passes through. (19,8) is red. (15,6) is red.
//     -> (21,8) passes through.
//  3. Overlap priority: slot0 = (0,50,0,50,00FF00), slot2 = (40,90,40,90,0000FF).
//     -> At (50,50) output is green with o_hit_idx=0. At (90,60) output is blue with o_hit_idx=2.
//  4. Double buffering: rewrite slot0 mid-frame at row 100.
//     -> Rows >100 of the same frame still use the old box. The new box appears only after the
//        next vsync rise.
//     -> cfg_we on the commit cycle lands one frame later.
//  5. Degenerate boxes: xs=30,xe=20 -> never hits. Box 3x3 with W=2 -> all 9 pixels hit.
//     -> xs=2040 with W=16 -> saturates without wrapping, so no spurious hit at x<16.
//     -> cfg_idx=N_BOX write is ignored.
//  6. BOX_OVERLAY_ALPHA_EN: colour FFFFFF over pixel 204060 -> output 8F9FAF.
//     -> Same stimulus without the macro -> output FFFFFF.

Source files
------------

// File: rtl/box_overlay_pkg.sv
// rtl/box_overlay_pkg.sv - box slot type, clear constant and blend helper for box_overlay
package box_overlay_pkg;

    localparam int BOX_X_W = 11;
    localparam int BOX_Y_W = 10;

    typedef struct packed {
        logic               en;
        logic [BOX_X_W-1:0] xs;
        logic [BOX_X_W-1:0] xe;
        logic [BOX_Y_W-1:0] ys;
        logic [BOX_Y_W-1:0] ye;
        logic [23:0]        color;
    } box_t;

    localparam box_t BOX_CLEAR = '0;

    // Halving both operands first keeps each channel sum within 8 bits.
    function automatic logic [23:0] blend50(input logic [23:0] color, input logic [23:0] pixel);
        logic [23:0] res;
        for (int c = 0; c < 3; c++) begin
            res[c*8 +: 8] = {1'b0, color[c*8+1 +: 7]} + {1'b0, pixel[c*8+1 +: 7]};
        end
        return res;
    endfunction

endpackage

// File: rtl/box_overlay_hit.sv
// rtl/box_overlay_hit.sv - combinational single-slot frame edge test (module box_hit)
module box_hit
    import box_overlay_pkg::*;
#(
    parameter int V_W = 2,
    parameter int H_W = 2
) (
    input  box_t               box,
    input  logic [BOX_X_W-1:0] x,
    input  logic [BOX_Y_W-1:0] y,
    output logic               hit
);
    localparam int XW1 = BOX_X_W + 1;
    localparam int YW1 = BOX_Y_W + 1;
    localparam logic [XW1-1:0] X_MAX = XW1'((1 << BOX_X_W) - 1);
    localparam logic [YW1-1:0] Y_MAX = YW1'((1 << BOX_Y_W) - 1);
    localparam logic [XW1-1:0] VW    = XW1'(V_W);
    localparam logic [YW1-1:0] HW    = YW1'(H_W);

    logic [XW1-1:0] xl, xr;
    logic [YW1-1:0] yt, yb;
    logic           in_rect, on_edge;

    // Inner-edge bounds saturate at the frame limits instead of wrapping.
    always_comb begin
        xl = {1'b0, box.xs} + VW;
        if (xl > X_MAX) xl = X_MAX;
        xr = ({1'b0, box.xe} >= VW) ? ({1'b0, box.xe} - VW) : '0;
        yt = {1'b0, box.ys} + HW;
        if (yt > Y_MAX) yt = Y_MAX;
        yb = ({1'b0, box.ye} >= HW) ? ({1'b0, box.ye} - HW) : '0;

        in_rect = box.en && (box.xs <= box.xe) && (box.ys <= box.ye) &&
                  (x >= box.xs) && (x <= box.xe) && (y >= box.ys) && (y <= box.ye);
        on_edge = ({1'b0, x} < xl) || ({1'b0, x} > xr) ||
                  ({1'b0, y} < yt) || ({1'b0, y} > yb);
        hit = in_rect && on_edge;
    end

endmodule

// File: rtl/box_overlay.sv
// rtl/box_overlay.sv - double-buffered multi-box frame overlay, 2-cycle pixel pipeline
// Optional build macro BOX_OVERLAY_ALPHA_EN selects 50% blending of edge pixels.
module box_overlay
    import box_overlay_pkg::*;
#(
    parameter int N_BOX       = 4,
    parameter int X_WIDTH     = 11,
    parameter int Y_WIDTH     = 10,
    parameter int V_BOX_WIDTH = 2,
    parameter int H_BOX_WIDTH = 2,
    localparam int IDX_W      = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic               cfg_en,
    input  logic [X_WIDTH-1:0] cfg_xs,
    input  logic [X_WIDTH-1:0] cfg_xe,
    input  logic [Y_WIDTH-1:0] cfg_ys,
    input  logic [Y_WIDTH-1:0] cfg_ye,
    input  logic [23:0]        cfg_color,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic               i_de,
    input  logic [X_WIDTH-1:0] i_x,
    input  logic [Y_WIDTH-1:0] i_y,
    input  logic [7:0]         i_r,
    input  logic [7:0]         i_g,
    input  logic [7:0]         i_b,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [7:0]         o_r,
    output logic [7:0]         o_g,
    output logic [7:0]         o_b,
    output logic               o_hit,
    output logic [IDX_W-1:0]   o_hit_idx
);
    box_t shadow [N_BOX];
    box_t active [N_BOX];
    logic vs_q;
    logic commit;

    assign commit = i_vsync && !vs_q;

    // Commit reads the pre-write shadow, so a write on the commit cycle lands a frame later.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= 1'b0;
            for (int k = 0; k < N_BOX; k++) begin
                shadow[k] <= BOX_CLEAR;
                active[k] <= BOX_CLEAR;
            end
        end else begin
            vs_q <= i_vsync;
            if (cfg_we && (int'(cfg_idx) < N_BOX)) begin
                shadow[cfg_idx] <= '{en: cfg_en, xs: cfg_xs, xe: cfg_xe,
                                     ys: cfg_ys, ye: cfg_ye, color: cfg_color};
            end
            if (commit) active <= shadow;
        end
    end

    logic [N_BOX-1:0] hit_c;

    for (genvar g = 0; g < N_BOX; g++) begin : g_hit
        box_hit #(.V_W(V_BOX_WIDTH), .H_W(H_BOX_WIDTH)) u_hit (
            .box (active[g]),
            .x   (i_x),
            .y   (i_y),
            .hit (hit_c[g])
        );
    end

    logic [N_BOX-1:0] s1_hit;
    logic [23:0]      s1_color [N_BOX];
    logic [23:0]      s1_pix;
    logic             s1_hs, s1_vs, s1_de;

    // Colours travel with the hit vector so a commit between stages cannot mix tables.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hit <= '0;
            s1_pix <= '0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
            s1_de  <= 1'b0;
            for (int k = 0; k < N_BOX; k++) s1_color[k] <= '0;
        end else begin
            s1_hit <= hit_c & {N_BOX{i_de}};
            s1_pix <= {i_r, i_g, i_b};
            s1_hs  <= i_hsync;
            s1_vs  <= i_vsync;
            s1_de  <= i_de;
            for (int k = 0; k < N_BOX; k++) s1_color[k] <= active[k].color;
        end
    end

    logic             win;
    logic [IDX_W-1:0] win_idx;
    logic [23:0]      win_color;
    logic [23:0]      edge_pix;

    always_comb begin
        win       = 1'b0;
        win_idx   = '0;
        win_color = '0;
        for (int k = N_BOX - 1; k >= 0; k--) begin
            if (s1_hit[k]) begin
                win       = 1'b1;
                win_idx   = IDX_W'(k);
                win_color = s1_color[k];
            end
        end
`ifdef BOX_OVERLAY_ALPHA_EN
        edge_pix = blend50(win_color, s1_pix);
`else
        edge_pix = win_color;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_hsync   <= 1'b0;
            o_vsync   <= 1'b0;
            o_de      <= 1'b0;
            {o_r, o_g, o_b} <= '0;
            o_hit     <= 1'b0;
            o_hit_idx <= '0;
        end else begin
            o_hsync   <= s1_hs;
            o_vsync   <= s1_vs;
            o_de      <= s1_de;
            {o_r, o_g, o_b} <= win ? edge_pix : s1_pix;
            o_hit     <= win;
            o_hit_idx <= win_idx;
        end
    end

endmodule

// File: tb/tb_box_overlay.sv
// tb/tb_box_overlay.sv - self-checking bench for box_overlay (plain and BOX_OVERLAY_ALPHA_EN builds)
module tb_box_overlay;

    localparam int NB = 3;
    localparam logic [23:0] BG = 24'h123456;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cfg_we, cfg_en;
    logic [1:0]  cfg_idx;
    logic [10:0] cfg_xs, cfg_xe;
    logic [9:0]  cfg_ys, cfg_ye;
    logic [23:0] cfg_color;
    logic        i_hs, i_vs, i_de;
    logic [10:0] i_x;
    logic [9:0]  i_y;
    logic [23:0] i_pix;

    logic       hs_a, vs_a, de_a, hit_a, hs_b, vs_b, de_b, hit_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic [1:0] idx_a, idx_b;

    box_overlay #(.N_BOX(NB), .V_BOX_WIDTH(2), .H_BOX_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_xs(cfg_xs), .cfg_xe(cfg_xe), .cfg_ys(cfg_ys), .cfg_ye(cfg_ye), .cfg_color(cfg_color),
        .i_hsync(i_hs), .i_vsync(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
        .i_r(i_pix[23:16]), .i_g(i_pix[15:8]), .i_b(i_pix[7:0]),
        .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a), .o_r(r_a), .o_g(g_a), .o_b(b_a),
        .o_hit(hit_a), .o_hit_idx(idx_a));

    box_overlay #(.N_BOX(NB), .V_BOX_WIDTH(16), .H_BOX_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_xs(cfg_xs), .cfg_xe(cfg_xe), .cfg_ys(cfg_ys), .cfg_ye(cfg_ye), .cfg_color(cfg_color),
        .i_hsync(i_hs), .i_vsync(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
        .i_r(i_pix[23:16]), .i_g(i_pix[15:8]), .i_b(i_pix[7:0]),
        .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b), .o_r(r_b), .o_g(g_b), .o_b(b_b),
        .o_hit(hit_b), .o_hit_idx(idx_b));

    typedef struct {int en, xs, xe, ys, ye, color;} mbox_t;
    typedef struct packed {logic hs, vs, de; logic [23:0] pix; logic hit; logic [1:0] idx;} out_t;
    typedef struct {string name; int x, y; logic [23:0] pix, exp; logic hit; int idx, which;} vec_t;

    mbox_t sh [NB];
    mbox_t ac [NB];
    int    vs_prev;
    out_t  pend_a, pend_b, cur_a, cur_b;
    vec_t  vq [$];
    int    total, bad;

    function automatic logic [23:0] paint(logic [23:0] c, logic [23:0] p);
`ifdef BOX_OVERLAY_ALPHA_EN
        int r, g, b;
        r = c[23:16] / 2 + p[23:16] / 2;
        g = c[15:8] / 2 + p[15:8] / 2;
        b = c[7:0] / 2 + p[7:0] / 2;
        return {8'(r), 8'(g), 8'(b)};
`else
        return c;
`endif
    endfunction

    function automatic bit mhit(mbox_t b, int x, int y, int w);
        int l, r, t, bt;
        if (b.en == 0 || b.xs > b.xe || b.ys > b.ye) return 0;
        if (x < b.xs || x > b.xe || y < b.ys || y > b.ye) return 0;
        l  = (b.xs + w > 2047) ? 2047 : b.xs + w;
        r  = (b.xe - w < 0) ? 0 : b.xe - w;
        t  = (b.ys + w > 1023) ? 1023 : b.ys + w;
        bt = (b.ye - w < 0) ? 0 : b.ye - w;
        return (x < l) || (x > r) || (y < t) || (y > bt);
    endfunction

    function automatic out_t model(int w);
        out_t o;
        o = '0;
        o.hs = i_hs; o.vs = i_vs; o.de = i_de; o.pix = i_pix;
        if (i_de) begin
            for (int k = 0; k < NB; k++) begin
                if (!o.hit && mhit(ac[k], int'(i_x), int'(i_y), w)) begin
                    o.hit = 1'b1;
                    o.idx = 2'(k);
                    o.pix = paint(24'(ac[k].color), i_pix);
                end
            end
        end
        return o;
    endfunction

    task automatic cmp(string name, logic [29:0] got, logic [29:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: model predicts, table state advances, both DUTs are compared.
    task automatic step();
        out_t ea, eb, xa, xb;
        bit   r;
        ea = model(2);
        eb = model(16);
        @(posedge clk);
        r  = rst;
        xa = r ? '0 : pend_a;
        xb = r ? '0 : pend_b;
        pend_a = r ? '0 : ea;
        pend_b = r ? '0 : eb;
        if (r) begin
            for (int k = 0; k < NB; k++) begin sh[k] = '{0,0,0,0,0,0}; ac[k] = '{0,0,0,0,0,0}; end
            vs_prev = 0;
        end else begin
            if (i_vs && vs_prev == 0) ac = sh;
            if (cfg_we && cfg_idx < NB)
                sh[cfg_idx] = '{int'(cfg_en), int'(cfg_xs), int'(cfg_xe), int'(cfg_ys), int'(cfg_ye), int'(cfg_color)};
            vs_prev = int'(i_vs);
        end
        @(negedge clk);
        cur_a = {hs_a, vs_a, de_a, r_a, g_a, b_a, hit_a, idx_a};
        cur_b = {hs_b, vs_b, de_b, r_b, g_b, b_b, hit_b, idx_b};
        cmp("pipe_w2", cur_a, xa);
        cmp("pipe_w16", cur_b, xb);
    endtask

    task automatic wr(int idx, int en, int xs, int xe, int ys, int ye, logic [23:0] col);
        cfg_idx = 2'(idx); cfg_en = en[0]; cfg_xs = 11'(xs); cfg_xe = 11'(xe);
        cfg_ys = 10'(ys); cfg_ye = 10'(ye); cfg_color = col; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic vsync_pulse();
        i_vs = 1'b1; step();
        i_vs = 1'b0; step();
    endtask

    task automatic add(string n, int x, int y, logic [23:0] p, logic [23:0] e, logic h, int idx, int which);
        vq.push_back('{n, x, y, p, e, h, idx, which});
    endtask

    task automatic run_vecs();
        out_t c;
        foreach (vq[i]) begin
            i_de = 1'b1; i_x = 11'(vq[i].x); i_y = 10'(vq[i].y); i_pix = vq[i].pix;
            step();
            i_de = 1'b0;
            step();
            c = (vq[i].which != 0) ? cur_b : cur_a;
            cmp(vq[i].name, {3'b0, c.pix, c.hit, c.idx}, {3'b0, vq[i].exp, vq[i].hit, 2'(vq[i].idx)});
        end
        vq.delete();
    endtask

    task automatic rand_inputs();
        i_hs = 1'($urandom); i_de = 1'($urandom); i_pix = 24'($urandom);
        i_x = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(2030, 2047)) : 11'($urandom_range(0, 100));
        i_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1010, 1023)) : 10'($urandom_range(0, 100));
    endtask

    initial begin
        int xs, ys;
        total = 0; bad = 0; vs_prev = 0; pend_a = '0; pend_b = '0;
        for (int k = 0; k < NB; k++) begin sh[k] = '{0,0,0,0,0,0}; ac[k] = '{0,0,0,0,0,0}; end
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_xs = '0; cfg_xe = '0;
        cfg_ys = '0; cfg_ye = '0; cfg_color = '0; i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0;
        i_x = '0; i_y = '0; i_pix = '0;

        // Reset with a live random stream, then pass-through with empty tables.
        for (int i = 0; i < 3; i++) begin rand_inputs(); i_vs = 1'($urandom); step(); end
        cmp("reset_outputs_zero", cur_a, '0);
        rst = 1'b0; i_vs = 1'b0;
        for (int i = 0; i < 10; i++) begin rand_inputs(); step(); end
        i_de = 1'b0; i_hs = 1'b0;

        // Single box.
        wr(0, 1, 10, 20, 5, 15, 24'hFF0000);
        vsync_pulse();
        add("box_left_edge", 10, 8, BG, paint(24'hFF0000, BG), 1, 0, 0);
        add("box_interior", 12, 8, BG, BG, 0, 0, 0);
        add("box_right_edge", 19, 8, BG, paint(24'hFF0000, BG), 1, 0, 0);
        add("box_top_edge", 15, 6, BG, paint(24'hFF0000, BG), 1, 0, 0);
        add("box_outside", 21, 8, BG, BG, 0, 0, 0);
        run_vecs();

        // Overlap priority.
        wr(0, 1, 0, 50, 0, 50, 24'h00FF00);
        wr(2, 1, 40, 90, 40, 90, 24'h0000FF);
        vsync_pulse();
        add("prio_low_wins", 50, 50, BG, paint(24'h00FF00, BG), 1, 0, 0);
        add("prio_slot2", 90, 60, BG, paint(24'h0000FF, BG), 1, 2, 0);
        add("prio_both_inner", 45, 45, BG, BG, 0, 0, 0);
        run_vecs();

        // Double buffering.
        wr(2, 0, 0, 0, 0, 0, 24'h0);
        wr(0, 1, 100, 200, 90, 150, 24'hFF0000);
        vsync_pulse();
        add("dbuf_old_row100", 100, 100, BG, paint(24'hFF0000, BG), 1, 0, 0);
        run_vecs();
        wr(0, 1, 300, 400, 90, 150, 24'h00FF00);
        add("dbuf_old_kept", 100, 110, BG, paint(24'hFF0000, BG), 1, 0, 0);
        add("dbuf_new_hidden", 300, 110, BG, BG, 0, 0, 0);
        run_vecs();
        vsync_pulse();
        add("dbuf_new_shown", 300, 110, BG, paint(24'h00FF00, BG), 1, 0, 0);
        add("dbuf_old_gone", 100, 110, BG, BG, 0, 0, 0);
        run_vecs();
        cfg_idx = 2'd0; cfg_en = 1'b1; cfg_xs = 11'd500; cfg_xe = 11'd600;
        cfg_ys = 10'd90; cfg_ye = 10'd150; cfg_color = 24'h0000FF; cfg_we = 1'b1; i_vs = 1'b1;
        step();
        cfg_we = 1'b0; i_vs = 1'b0;
        step();
        add("commit_cycle_write_late", 500, 110, BG, BG, 0, 0, 0);
        add("commit_cycle_prev_box", 300, 110, BG, paint(24'h00FF00, BG), 1, 0, 0);
        run_vecs();
        vsync_pulse();
        add("commit_cycle_write_lands", 500, 110, BG, paint(24'h0000FF, BG), 1, 0, 0);
        run_vecs();

        // Degenerate boxes and ignored slot index.
        wr(0, 1, 30, 20, 0, 40, 24'hFFFFFF);
        wr(1, 1, 60, 62, 60, 62, 24'h00FF00);
        wr(2, 1, 2040, 2047, 0, 40, 24'hFF00FF);
        wr(3, 1, 0, 2047, 0, 1023, 24'hFFFFFF);
        vsync_pulse();
        add("inverted_box", 25, 10, BG, BG, 0, 0, 0);
        add("idx_out_of_range", 0, 0, BG, BG, 0, 0, 0);
        for (int yy = 60; yy <= 62; yy++)
            for (int xx = 60; xx <= 62; xx++)
                add("tiny_box_fill", xx, yy, BG, paint(24'h00FF00, BG), 1, 1, 0);
        add("edge_max_w2_inner", 2045, 20, BG, BG, 0, 0, 0);
        add("edge_max_w2_right", 2047, 20, BG, paint(24'hFF00FF, BG), 1, 2, 0);
        add("sat_w16_hit", 2045, 20, BG, paint(24'hFF00FF, BG), 1, 2, 1);
        add("sat_w16_no_wrap", 5, 20, BG, BG, 0, 0, 1);
        run_vecs();

        // Edge colour: replace or 50% blend.
        wr(0, 1, 100, 110, 100, 110, 24'hFFFFFF);
        vsync_pulse();
`ifdef BOX_OVERLAY_ALPHA_EN
        add("edge_colour_blend", 100, 105, 24'h204060, 24'h8F9FAF, 1, 0, 0);
`else
        add("edge_colour_replace", 100, 105, 24'h204060, 24'hFFFFFF, 1, 0, 0);
`endif
        run_vecs();

        // Random traffic against the model, with one mid-stream reset.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            i_vs = ($urandom_range(0, 15) == 0);
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                xs = $urandom_range(2030, 2047); cfg_xs = 11'(xs); cfg_xe = 11'd2047;
            end else begin
                xs = $urandom_range(0, 60); cfg_xs = 11'(xs);
                xs = xs + $urandom_range(0, 35) - 5; cfg_xe = 11'((xs < 0) ? 0 : xs);
            end
            if ($urandom_range(0, 7) == 0) begin
                ys = $urandom_range(1010, 1023); cfg_ys = 10'(ys); cfg_ye = 10'd1023;
            end else begin
                ys = $urandom_range(0, 60); cfg_ys = 10'(ys);
                ys = ys + $urandom_range(0, 35) - 5; cfg_ye = 10'((ys < 0) ? 0 : ys);
            end
            cfg_color = 24'($urandom);
            rst = (i >= 1500 && i < 1502);
            step();
        end
        rst = 1'b0; cfg_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
